// File: rtl/p2p_frame_responder_if.sv
// p2p_frame_responder_if: word stream between the point_slave_io slot and the frame responder.
interface p2p_frame_responder_if;
  logic [15:0] data_o;
  logic [15:0] data_i;
  logic        busy;
  logic        frame_err;
  modport master (output data_o, input data_i, busy, frame_err);
  modport slave (input data_o, output data_i, busy, frame_err);
endinterface

// File: rtl/p2p_frame_responder.sv
// p2p_frame_responder: checks request frames from the slot and answers with inverted payload plus checksum.
// Optional: define P2P_RESP_ERRCNT_EN to add a saturating err_count output.
module p2p_frame_responder #(
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] REQ_TAG = 8'hA5,
  parameter logic [7:0] RSP_TAG = 8'h5A
) (
  input  logic                 clock,
  input  logic                 reset_n,
  p2p_frame_responder_if.slave bus
`ifdef P2P_RESP_ERRCNT_EN
  ,
  output logic [7:0]           err_count
`endif
);
  localparam logic [2:0] IDLE = 3'd0, RX_PAY = 3'd1, RX_SUM = 3'd2, TX_PAY = 3'd3, TX_SUM = 3'd4;
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXL = MAX_LEN[7:0];
  logic [2:0]  state_q, state_d;
  logic [7:0]  len_q, len_d, idx_q, idx_d;
  logic [15:0] sum_q, sum_d, data_q, data_d, tx_w;
  logic        err_q, err_d, last, hdr, len_ok;
  logic [15:0] buf_q [2**IW];
  assign hdr    = bus.data_o[15:8] == REQ_TAG;
  assign len_ok = bus.data_o[7:0] != 8'd0 && bus.data_o[7:0] <= MAXL;
  assign last   = idx_q + 8'd1 == len_q;
  assign tx_w   = ~buf_q[idx_q[IW-1:0]];
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    data_d  = 16'h0000;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (hdr) begin
        if (len_ok) begin
          state_d = RX_PAY;
          len_d   = bus.data_o[7:0];
          sum_d   = bus.data_o;
          idx_d   = 8'd0;
        end else err_d = 1'b1;
      end
      RX_PAY: begin
        sum_d   = sum_q + bus.data_o;
        idx_d   = last ? 8'd0 : idx_q + 8'd1;
        state_d = last ? RX_SUM : RX_PAY;
      end
      RX_SUM: if (bus.data_o == sum_q) begin
        data_d  = {RSP_TAG, len_q};
        sum_d   = {RSP_TAG, len_q};
        idx_d   = 8'd0;
        state_d = TX_PAY;
      end else begin
        data_d  = {8'hEE, len_q};
        err_d   = 1'b1;
        state_d = IDLE;
      end
      TX_PAY: begin
        data_d  = tx_w;
        sum_d   = sum_q + tx_w;
        idx_d   = last ? 8'd0 : idx_q + 8'd1;
        state_d = last ? TX_SUM : TX_PAY;
      end
      TX_SUM: begin
        data_d  = sum_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q   <= 8'd0;
      idx_q   <= 8'd0;
      sum_q   <= 16'h0000;
      data_q  <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
  // payload buffer needs no reset; it is always written before being read
  always_ff @(posedge clock) begin
    if (state_q == RX_PAY) buf_q[idx_q[IW-1:0]] <= bus.data_o;
  end
  assign bus.data_i    = data_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = state_q != IDLE;
`ifdef P2P_RESP_ERRCNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= 8'd0;
    else if (err_d && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end
  assign err_count = cnt_q;
`endif
endmodule
